lmac_txfifo_rd_sched: RTL and testbench
=======================================

Name: lmac_txfifo_rd_sched

Overview:
Read-side scheduler for the LMAC TX FIFO. It paces FIFO pops to the active link rate (10G/5G/2.5G/1G) and holds reads until a start threshold is met, so a frame never starts on a near-empty FIFO. It tracks underflow during streaming and presents a one-cycle-delayed data-valid strobe aligned with FIFO read data. It sits between the TX FIFO (RD_EN/EMPTY/WUSED) and the downstream TX encoder.

Parameters:
USED_W, 13, width of FIFO occupancy input (matches TXFIFO_WUSED_QWD)
START_THRESH, 4, occupancy (qwords) required to leave PREFILL
DEPTH, 16, FIFO depth in qwords; START_THRESH must be <= DEPTH

Ports:
clk  in  1  core clock, rising edge
rst  in  1  synchronous reset, active-high
MODE_10G  in  1  link rate select
MODE_5G  in  1  link rate select
MODE_2P5G  in  1  link rate select
MODE_1G  in  1  link rate select
TX_EN  in  1  downstream requests transmission; level-sensitive
FRAME_END  in  1  one-cycle pulse: last qword of current frame has been popped
FIFO_EMPTY  in  1  TX FIFO empty flag
FIFO_USED  in  USED_W  TX FIFO occupancy, qwords
RD_EN  out  1  FIFO pop strobe, one qword per asserted cycle
RD_VALID  out  1  FIFO read data valid (RD_EN delayed 1 cycle)
UNDERFLOW  out  1  sticky: pop slot found FIFO empty while STREAM
SCHED_STATE  out  2  current state encoding
BUSY  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, pace counter=0, RD_EN=0, RD_VALID=0, UNDERFLOW=0, BUSY=0, SCHED_STATE=2'd0. Reset mid-frame aborts immediately; RD_VALID clears in the same edge, with no trailing pulse.
- Rate decode, priority 10G>5G>2P5G>1G. Pace divisor P: 10G=1, 5G=2, 2P5G=4, 1G=10. No mode bit set -> rate invalid.
- Pace counter: 4-bit. Counts 0..P-1 while in STREAM. A pop slot occurs when the counter is 0. It wraps to 0 after P-1. It is forced to 0 on STREAM entry, so the first pop occurs in the first STREAM cycle. A mode change mid-STREAM resets the counter to 0 on the next cycle.
- States (SCHED_STATE): IDLE=0, PREFILL=1, STREAM=2, HOLD=3.
- IDLE -> PREFILL when TX_EN=1 and rate valid.
- PREFILL -> STREAM when FIFO_USED >= START_THRESH; compare is unsigned at USED_W bits. PREFILL -> IDLE if TX_EN=0 or rate invalid.
- STREAM: RD_EN=1 on a pop slot when FIFO_EMPTY=0, else RD_EN=0.
  - Pop slot with FIFO_EMPTY=1 -> UNDERFLOW set (sticky until rst), transition to HOLD.
  - FRAME_END=1 -> IDLE if TX_EN=0, else PREFILL.
  - FRAME_END takes priority over a simultaneous underflow; no flag is set in that case.
  - TX_EN deassert mid-frame does not stop streaming; only FRAME_END ends a frame.
- HOLD: RD_EN=0. HOLD -> STREAM when FIFO_USED >= START_THRESH. HOLD -> IDLE on FRAME_END.
- RD_EN is registered: it asserts in the cycle after the decision and is never high when FIFO_EMPTY was 1 in the deciding cycle.
- RD_VALID <= RD_EN (1-cycle latency, matching FIFO registered read output).
- Rate invalid while in STREAM or HOLD -> IDLE next cycle, RD_EN=0.
- Throughput is exactly one pop per P cycles in steady state with a non-empty FIFO.
- BUSY=1 in PREFILL, STREAM and HOLD.

Optional Feature:
LMAC_TXSCHED_UFCNT_EN
- Defined: adds output UF_COUNT[15:0], reset 0. It increments on each STREAM->HOLD underflow transition and saturates at 16'hFFFF.
- Not defined: port absent and no counter logic; UNDERFLOW sticky behaviour is unchanged.

Test Plan:
- Reset then MODE_10G=1, TX_EN=1, FIFO_USED ramps 0->4 -> PREFILL until USED=4, then RD_EN high every cycle and RD_VALID exactly 1 cycle behind.
- MODE_1G=1, FIFO_USED=16, streaming for 30 cycles -> exactly 3 RD_EN pulses, spaced 10 cycles apart, first pulse in the first STREAM cycle.
- MODE_5G and MODE_1G both set -> divisor 2 (5G wins); RD_EN on alternating cycles.
- STREAM in 2P5G, FIFO_EMPTY=1 at a pop slot -> RD_EN=0, UNDERFLOW=1, SCHED_STATE=3. USED then rises to 4 -> STREAM resumes; UNDERFLOW stays 1 (UF_COUNT=1 if macro defined).
- FRAME_END with TX_EN=1 -> PREFILL. FRAME_END with TX_EN=0 -> IDLE, BUSY=0. FRAME_END coinciding with an empty pop slot -> IDLE/PREFILL, UNDERFLOW stays 0.
- rst asserted in STREAM the cycle after RD_EN=1 -> next edge: RD_EN=0, RD_VALID=0, SCHED_STATE=0, UNDERFLOW=0.

Source files
------------

// File: rtl/lmac_txfifo_rd_sched_if.sv
// ---------------------------------------------------------------------------
// lmac_txfifo_rd_sched_if
//
// Purpose: bundles the link-rate selects, the TX FIFO status/pop handshake
// and the scheduler status outputs of lmac_txfifo_rd_sched into one port.
//
// Signals:
//   MODE_10G/MODE_5G/MODE_2P5G/MODE_1G  link rate selects (to scheduler)
//   TX_EN        downstream transmit request, level (to scheduler)
//   FRAME_END    pulse, last qword of frame popped (to scheduler)
//   FIFO_EMPTY   TX FIFO empty flag (to scheduler)
//   FIFO_USED    TX FIFO occupancy in qwords (to scheduler)
//   RD_EN        FIFO pop strobe (from scheduler)
//   RD_VALID     FIFO read data valid, RD_EN delayed 1 cycle (from scheduler)
//   UNDERFLOW    sticky underflow flag (from scheduler)
//   SCHED_STATE  scheduler state encoding (from scheduler)
//   BUSY         scheduler not idle (from scheduler)
//   UF_COUNT     saturating underflow counter, only with
//                LMAC_TXSCHED_UFCNT_EN defined (from scheduler)
//
// Modports: master = scheduler side, slave = FIFO/encoder/environment side.
// ---------------------------------------------------------------------------
interface lmac_txfifo_rd_sched_if #(
    parameter int USED_W = 13
);
    logic              MODE_10G;
    logic              MODE_5G;
    logic              MODE_2P5G;
    logic              MODE_1G;
    logic              TX_EN;
    logic              FRAME_END;
    logic              FIFO_EMPTY;
    logic [USED_W-1:0] FIFO_USED;
    logic              RD_EN;
    logic              RD_VALID;
    logic              UNDERFLOW;
    logic [1:0]        SCHED_STATE;
    logic              BUSY;
`ifdef LMAC_TXSCHED_UFCNT_EN
    logic [15:0]       UF_COUNT;

    modport master (
        input  MODE_10G, MODE_5G, MODE_2P5G, MODE_1G,
        input  TX_EN, FRAME_END, FIFO_EMPTY, FIFO_USED,
        output RD_EN, RD_VALID, UNDERFLOW, SCHED_STATE, BUSY, UF_COUNT
    );

    modport slave (
        output MODE_10G, MODE_5G, MODE_2P5G, MODE_1G,
        output TX_EN, FRAME_END, FIFO_EMPTY, FIFO_USED,
        input  RD_EN, RD_VALID, UNDERFLOW, SCHED_STATE, BUSY, UF_COUNT
    );
`else
    modport master (
        input  MODE_10G, MODE_5G, MODE_2P5G, MODE_1G,
        input  TX_EN, FRAME_END, FIFO_EMPTY, FIFO_USED,
        output RD_EN, RD_VALID, UNDERFLOW, SCHED_STATE, BUSY
    );

    modport slave (
        output MODE_10G, MODE_5G, MODE_2P5G, MODE_1G,
        output TX_EN, FRAME_END, FIFO_EMPTY, FIFO_USED,
        input  RD_EN, RD_VALID, UNDERFLOW, SCHED_STATE, BUSY
    );
`endif
endinterface

// File: rtl/lmac_txfifo_rd_sched.sv
// ---------------------------------------------------------------------------
// lmac_txfifo_rd_sched
//
// Purpose: read-side scheduler for the LMAC TX FIFO. Paces FIFO pops to the
// active link rate (10G/5G/2.5G/1G = one pop every 1/2/4/10 cycles), holds
// off reading until the FIFO holds START_THRESH qwords, flags underflow while
// streaming and produces a read-valid strobe aligned with the FIFO's
// registered read data.
//
// Ports:
//   clk   core clock, rising edge
//   rst   synchronous reset, active-high
//   bus   lmac_txfifo_rd_sched_if.master (rate selects, TX_EN, FRAME_END,
//         FIFO_EMPTY/FIFO_USED in; RD_EN, RD_VALID, UNDERFLOW, SCHED_STATE,
//         BUSY out)
//
// Optional feature macro: LMAC_TXSCHED_UFCNT_EN
//   Defined: bus.UF_COUNT[15:0] counts STREAM->HOLD underflow transitions,
//   saturating at 16'hFFFF. Undefined: no counter, no port.
// ---------------------------------------------------------------------------
module lmac_txfifo_rd_sched #(
    parameter int USED_W       = 13,
    parameter int START_THRESH = 4,
    parameter int DEPTH        = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    lmac_txfifo_rd_sched_if.master       bus
);

    // A threshold above the FIFO depth could never be reached, so clamp it.
    localparam int THRESH_EFF = (START_THRESH > DEPTH) ? DEPTH : START_THRESH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PREFILL = 2'd1,
        S_STREAM  = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_paceCnt;
    logic [3:0]  r_paceDiv;
    logic [3:0]  w_paceDiv;
    logic        w_rateValid;
    logic        w_threshMet;
    logic        w_popSlot;
    logic        w_rdEnNext;
    logic        w_ufSet;
    logic        r_rdEn;
    logic        r_rdValid;
    logic        r_underflow;

    // Rate decode with 10G > 5G > 2.5G > 1G priority; divisor 0 means no
    // valid rate is selected.
    always_comb begin
        w_paceDiv = 4'd0;
        if (bus.MODE_10G) begin
            w_paceDiv = 4'd1;
        end else if (bus.MODE_5G) begin
            w_paceDiv = 4'd2;
        end else if (bus.MODE_2P5G) begin
            w_paceDiv = 4'd4;
        end else if (bus.MODE_1G) begin
            w_paceDiv = 4'd10;
        end
    end

    assign w_rateValid = (w_paceDiv != 4'd0);
    assign w_threshMet = (bus.FIFO_USED >= USED_W'(THRESH_EFF));
    assign w_popSlot   = (r_state == S_STREAM) && (r_paceCnt == 4'd0);

    // Next-state and pop decision. In STREAM a lost rate wins, then
    // FRAME_END (which also suppresses the pop and any underflow), then the
    // pop slot itself decides between popping and underflowing into HOLD.
    always_comb begin
        w_nextState = r_state;
        w_rdEnNext  = 1'b0;
        w_ufSet     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.TX_EN && w_rateValid) begin
                    w_nextState = S_PREFILL;
                end
            end
            S_PREFILL: begin
                if (!bus.TX_EN || !w_rateValid) begin
                    w_nextState = S_IDLE;
                end else if (w_threshMet) begin
                    w_nextState = S_STREAM;
                end
            end
            S_STREAM: begin
                if (!w_rateValid) begin
                    w_nextState = S_IDLE;
                end else if (bus.FRAME_END) begin
                    w_nextState = bus.TX_EN ? S_PREFILL : S_IDLE;
                end else if (w_popSlot) begin
                    if (bus.FIFO_EMPTY) begin
                        w_ufSet     = 1'b1;
                        w_nextState = S_HOLD;
                    end else begin
                        w_rdEnNext  = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (!w_rateValid || bus.FRAME_END) begin
                    w_nextState = S_IDLE;
                end else if (w_threshMet) begin
                    w_nextState = S_STREAM;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Pace counter. Held at 0 outside STREAM so the first STREAM cycle is a
    // pop slot. The divisor of the previous cycle is remembered so that a
    // rate change mid-stream restarts the count on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_paceCnt <= 4'd0;
            r_paceDiv <= 4'd0;
        end else begin
            r_paceDiv <= w_paceDiv;
            if ((r_state != S_STREAM) || (w_paceDiv != r_paceDiv)) begin
                r_paceCnt <= 4'd0;
            end else if (r_paceCnt >= 4'(w_paceDiv - 4'd1)) begin
                r_paceCnt <= 4'd0;
            end else begin
                r_paceCnt <= r_paceCnt + 4'd1;
            end
        end
    end

    // Registered pop strobe and its one-cycle-delayed valid, matching the
    // FIFO's registered read port. Reset kills both on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdEn    <= 1'b0;
            r_rdValid <= 1'b0;
        end else begin
            r_rdEn    <= w_rdEnNext;
            r_rdValid <= r_rdEn;
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_underflow <= 1'b0;
        end else if (w_ufSet) begin
            r_underflow <= 1'b1;
        end
    end

`ifdef LMAC_TXSCHED_UFCNT_EN
    logic [15:0] r_ufCount;

    // Saturating count of underflow events (STREAM->HOLD transitions).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ufCount <= 16'd0;
        end else if (w_ufSet && (r_ufCount != 16'hFFFF)) begin
            r_ufCount <= r_ufCount + 16'd1;
        end
    end

    assign bus.UF_COUNT = r_ufCount;
`endif

    assign bus.RD_EN       = r_rdEn;
    assign bus.RD_VALID    = r_rdValid;
    assign bus.UNDERFLOW   = r_underflow;
    assign bus.SCHED_STATE = r_state;
    assign bus.BUSY        = (r_state != S_IDLE);

endmodule

// File: tb/tb_lmac_txfifo_rd_sched.sv
// ---------------------------------------------------------------------------
// tb_lmac_txfifo_rd_sched
//
// Purpose: scoreboard bench for lmac_txfifo_rd_sched. Each stimulus cycle
// advances a behavioural model (pop slots computed from elapsed stream
// cycles modulo the rate divisor) and queues the expected outputs; a
// separate monitor pops and compares one entry per clock.
// ---------------------------------------------------------------------------
module tb_lmac_txfifo_rd_sched;

    localparam int USED_W       = 13;
    localparam int START_THRESH = 4;

    typedef struct packed {
        logic        rdEn;
        logic        rdValid;
        logic        underflow;
        logic [1:0]  state;
        logic        busy;
        logic [15:0] ufCount;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lmac_txfifo_rd_sched_if #(.USED_W(USED_W)) bus ();

    lmac_txfifo_rd_sched #(
        .USED_W      (USED_W),
        .START_THRESH(START_THRESH),
        .DEPTH       (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t expQ[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    // Reference model state: mPhase counts stream cycles since stream entry
    // or the last rate change; mPrevP is the divisor seen last cycle.
    int mState  = 0;
    int mPhase  = 0;
    int mPrevP  = 0;
    bit mRdEn   = 0;
    bit mRdValid = 0;
    bit mUf     = 0;
    int mUfCnt  = 0;

    function automatic int paceOf(input logic [3:0] modes);
        if (modes[3]) return 1;
        if (modes[2]) return 2;
        if (modes[1]) return 4;
        if (modes[0]) return 10;
        return 0;
    endfunction

    // Drive one cycle of inputs (modes = {10G,5G,2P5G,1G}), step the model
    // and queue what the DUT must show after the coming rising edge.
    task automatic applyStimulus(input bit r, input logic [3:0] modes,
                                 input bit txEn, input bit frameEnd,
                                 input int used, input bit empty);
        int   p;
        int   nxt;
        bit   slot;
        bit   pop;
        bit   uf;
        exp_t e;
        @(negedge clk);
        rst            = r;
        bus.MODE_10G   = modes[3];
        bus.MODE_5G    = modes[2];
        bus.MODE_2P5G  = modes[1];
        bus.MODE_1G    = modes[0];
        bus.TX_EN      = txEn;
        bus.FRAME_END  = frameEnd;
        bus.FIFO_USED  = USED_W'(used);
        bus.FIFO_EMPTY = empty;
        if (r) begin
            mState = 0; mPhase = 0; mPrevP = 0;
            mRdEn = 0; mRdValid = 0; mUf = 0; mUfCnt = 0;
        end else begin
            p    = paceOf(modes);
            slot = (mState == 2) &&
                   ((mPrevP == 0) ? (mPhase == 0) : ((mPhase % mPrevP) == 0));
            pop  = 0;
            uf   = 0;
            nxt  = mState;
            case (mState)
                0: if (txEn && p != 0) nxt = 1;
                1: begin
                    if (!txEn || p == 0) nxt = 0;
                    else if (used >= START_THRESH) nxt = 2;
                end
                2: begin
                    if (p == 0) nxt = 0;
                    else if (frameEnd) nxt = txEn ? 1 : 0;
                    else if (slot) begin
                        if (empty) begin uf = 1; nxt = 3; end
                        else pop = 1;
                    end
                end
                default: begin
                    if (p == 0 || frameEnd) nxt = 0;
                    else if (used >= START_THRESH) nxt = 2;
                end
            endcase
            mPhase   = (mState == 2 && p == mPrevP) ? mPhase + 1 : 0;
            mPrevP   = p;
            mRdValid = mRdEn;
            mRdEn    = pop;
            if (uf) begin
                mUf = 1;
                if (mUfCnt < 65535) mUfCnt++;
            end
            mState = nxt;
        end
        e.rdEn      = mRdEn;
        e.rdValid   = mRdValid;
        e.underflow = mUf;
        e.state     = 2'(mState);
        e.busy      = (mState != 0);
        e.ufCount   = 16'(mUfCnt);
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        exp_t a;
        a         = e;
        a.rdEn      = bus.RD_EN;
        a.rdValid   = bus.RD_VALID;
        a.underflow = bus.UNDERFLOW;
        a.state     = bus.SCHED_STATE;
        a.busy      = bus.BUSY;
`ifdef LMAC_TXSCHED_UFCNT_EN
        a.ufCount   = bus.UF_COUNT;
`endif
        checks++;
        if (a === e) begin
            passes++;
        end else begin
            fails++;
            $display("[TB] FAIL outputs @%0t: got rdEn=%b rdValid=%b uf=%b st=%0d busy=%b ufc=%0d, need rdEn=%b rdValid=%b uf=%b st=%0d busy=%b ufc=%0d",
                     $time, a.rdEn, a.rdValid, a.underflow, a.state, a.busy, a.ufCount,
                     e.rdEn, e.rdValid, e.underflow, e.state, e.busy, e.ufCount);
        end
    endtask

    // Monitor: one expectation per clock, sampled just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        logic [3:0] modes;
        bit         txEn;
        bit         fe;
        bit         emp;
        int         used;
        rst = 1'b1;
        bus.MODE_10G = 0; bus.MODE_5G = 0; bus.MODE_2P5G = 0; bus.MODE_1G = 0;
        bus.TX_EN = 0; bus.FRAME_END = 0; bus.FIFO_EMPTY = 1; bus.FIFO_USED = '0;

        // Reset state.
        repeat (2) applyStimulus(1, 4'b0000, 0, 0, 0, 1);

        // 10G: prefill while occupancy ramps 0->4, then pop every cycle.
        for (int u = 0; u <= 4; u++) begin
            applyStimulus(0, 4'b1000, 1, 0, u, u == 0);
            applyStimulus(0, 4'b1000, 1, 0, u, u == 0);
        end
        repeat (8) applyStimulus(0, 4'b1000, 1, 0, 8, 0);
        applyStimulus(0, 4'b1000, 0, 1, 8, 0);     // FRAME_END, TX_EN=0 -> IDLE
        applyStimulus(0, 4'b1000, 0, 0, 8, 0);

        // 1G with a full FIFO: 30 streaming cycles, pop every 10.
        repeat (2) applyStimulus(0, 4'b0001, 1, 0, 16, 0);
        repeat (30) applyStimulus(0, 4'b0001, 1, 0, 16, 0);
        applyStimulus(0, 4'b0001, 1, 1, 16, 0);    // FRAME_END, TX_EN=1 -> PREFILL

        // 5G and 1G both set: 5G wins, pop on alternate cycles.
        repeat (12) applyStimulus(0, 4'b0101, 1, 0, 16, 0);
        applyStimulus(0, 4'b0101, 0, 1, 16, 0);

        // 2.5G: FRAME_END on an empty pop slot -> no underflow.
        applyStimulus(0, 4'b0010, 1, 0, 8, 0);     // IDLE -> PREFILL
        applyStimulus(0, 4'b0010, 1, 0, 8, 0);     // PREFILL -> STREAM
        applyStimulus(0, 4'b0010, 1, 1, 0, 1);     // slot, empty, FRAME_END
        applyStimulus(0, 4'b0010, 1, 0, 8, 0);     // PREFILL -> STREAM
        applyStimulus(0, 4'b0010, 1, 0, 0, 1);     // slot, empty -> HOLD
        repeat (3) applyStimulus(0, 4'b0010, 1, 0, 2, 0);
        applyStimulus(0, 4'b0010, 1, 0, 4, 0);     // HOLD -> STREAM
        repeat (9) applyStimulus(0, 4'b0010, 1, 0, 6, 0);

        // Reset the cycle after a pop in STREAM.
        applyStimulus(1, 4'b0000, 0, 0, 0, 1);
        repeat (3) applyStimulus(0, 4'b1000, 1, 0, 8, 0);
        applyStimulus(1, 4'b1000, 1, 0, 8, 0);
        applyStimulus(0, 4'b0000, 0, 0, 8, 0);

        // Randomized traffic.
        modes = 4'b1000;
        txEn  = 1;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 9))
                    0:       modes = 4'b0000;
                    1, 2:    modes = 4'($urandom_range(0, 15));
                    default: modes = 4'(1 << $urandom_range(0, 3));
                endcase
            end
            if ($urandom_range(0, 19) == 0) txEn = ~txEn;
            fe   = ($urandom_range(0, 24) == 0);
            emp  = ($urandom_range(0, 5) == 0);
            used = emp ? 0 : (($urandom_range(0, 30) == 0) ? 8191 : $urandom_range(1, 16));
            applyStimulus($urandom_range(0, 299) == 0, modes, txEn, fe, used, emp);
        end
        applyStimulus(0, 4'b0000, 0, 0, 0, 1);
        @(posedge clk);
        #2;

        checks++;
        if (expQ.size() == 0) begin
            passes++;
        end else begin
            fails++;
            $display("[TB] FAIL drain: got %0d pending, need 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
